adder_share_arbiter: RTL and testbench

//  Shares one N-bit ripple-carry adder datapath among NREQ requesters.
//  - Round-robin arbiter picks one requester and captures its operands.
//  - A settle counter lets the ripple chain resolve before the result is registered.
//  - The result is returned on a valid/ready response channel tagged with the requester ID.
//  - One operation in flight at a time.

---
 rtl/adder_share_arbiter.sv | 174 +++++++++++++++++
 tb/tb_adder_share_arbiter.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/adder_share_arbiter.sv
// Round-robin shared N-bit ripple-carry adder: one operation in flight,
// result returned on a valid/ready channel tagged with the requester index.
module adder_share_arbiter #(
    parameter int N      = 8,
    parameter int NREQ   = 4,
    parameter int ID_W   = 2,
    parameter int SETTLE = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NREQ-1:0]   req,
    input  logic [NREQ*N-1:0] a_bus,
    input  logic [NREQ*N-1:0] b_bus,
    input  logic [NREQ-1:0]   cin,
    output logic [NREQ-1:0]   gnt,
    output logic              busy,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [ID_W-1:0]   rsp_id,
    output logic [N-1:0]      rsp_sum,
    output logic              rsp_cout
);

    localparam int CNT_W = (SETTLE > 1) ? $clog2(SETTLE) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_SETTLE,
        S_RESP
    } state_t;

    state_t              r_state;
    state_t              w_next_state;
    logic [ID_W-1:0]     r_ptr;
    logic [ID_W-1:0]     r_sel;
    logic [CNT_W-1:0]    r_cnt;
    logic [N-1:0]        r_a;
    logic [N-1:0]        r_b;
    logic                r_cin;
    logic [NREQ-1:0]     r_gnt;
    logic                r_rsp_valid;
    logic [ID_W-1:0]     r_rsp_id;
    logic [N-1:0]        r_rsp_sum;
    logic                r_rsp_cout;

    logic                w_hi_found;
    logic                w_lo_found;
    logic [ID_W-1:0]     w_hi;
    logic [ID_W-1:0]     w_lo;
    logic                w_found;
    logic [ID_W-1:0]     w_pick;
    logic [ID_W-1:0]     w_ptr_next;
    logic [NREQ-1:0]     w_onehot;
    logic [N-1:0]        w_a;
    logic [N-1:0]        w_b;
    logic                w_c;
    logic [N:0]          w_carry;
    logic [N-1:0]        w_sum;

    // Round-robin: lowest requester at or above ptr wins, else lowest overall (wrap).
    always_comb begin
        w_hi_found = 1'b0;
        w_lo_found = 1'b0;
        w_hi       = '0;
        w_lo       = '0;
        for (int unsigned k = 0; k < NREQ; k++) begin
            if (req[k] && !w_hi_found && (ID_W'(k) >= r_ptr)) begin
                w_hi_found = 1'b1;
                w_hi       = ID_W'(k);
            end
            if (req[k] && !w_lo_found) begin
                w_lo_found = 1'b1;
                w_lo       = ID_W'(k);
            end
        end
        w_found    = w_hi_found | w_lo_found;
        w_pick     = w_hi_found ? w_hi : w_lo;
        w_ptr_next = (w_pick == ID_W'(NREQ - 1)) ? '0 : w_pick + 1'b1;
    end

    always_comb begin
        w_onehot = '0;
        w_a      = '0;
        w_b      = '0;
        w_c      = 1'b0;
        for (int unsigned k = 0; k < NREQ; k++) begin
            if (w_found && (ID_W'(k) == w_pick)) begin
                w_onehot[k] = 1'b1;
                w_a         = a_bus[k*N +: N];
                w_b         = b_bus[k*N +: N];
                w_c         = cin[k];
            end
        end
    end

    // Shared ripple-carry datapath fed only from the latched operands.
    always_comb begin
        w_carry    = '0;
        w_sum      = '0;
        w_carry[0] = r_cin;
        for (int unsigned i = 0; i < N; i++) begin
            w_sum[i]     = r_a[i] ^ r_b[i] ^ w_carry[i];
            w_carry[i+1] = (r_a[i] & r_b[i]) | (w_carry[i] & (r_a[i] ^ r_b[i]));
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_next_state;
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE:   if (w_found) w_next_state = S_SETTLE;
            S_SETTLE: if (r_cnt == '0) w_next_state = S_RESP;
            S_RESP:   if (r_rsp_valid && rsp_ready) w_next_state = S_IDLE;
            default:  w_next_state = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ptr       <= '0;
            r_sel       <= '0;
            r_cnt       <= '0;
            r_a         <= '0;
            r_b         <= '0;
            r_cin       <= 1'b0;
            r_gnt       <= '0;
            r_rsp_valid <= 1'b0;
            r_rsp_id    <= '0;
            r_rsp_sum   <= '0;
            r_rsp_cout  <= 1'b0;
        end else begin
            r_gnt <= '0;
            case (r_state)
                S_IDLE: begin
                    if (w_found) begin
                        r_a   <= w_a;
                        r_b   <= w_b;
                        r_cin <= w_c;
                        r_gnt <= w_onehot;
                        r_sel <= w_pick;
                        r_ptr <= w_ptr_next;
                        r_cnt <= CNT_W'(SETTLE - 1);
                    end
                end
                S_SETTLE: begin
                    if (r_cnt != '0) begin
                        r_cnt <= r_cnt - 1'b1;
                    end else begin
                        r_rsp_sum   <= w_sum;
                        r_rsp_cout  <= w_carry[N];
                        r_rsp_id    <= r_sel;
                        r_rsp_valid <= 1'b1;
                    end
                end
                S_RESP: begin
                    if (r_rsp_valid && rsp_ready) r_rsp_valid <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    assign gnt       = r_gnt;
    assign busy      = (r_state != S_IDLE);
    assign rsp_valid = r_rsp_valid;
    assign rsp_id    = r_rsp_id;
    assign rsp_sum   = r_rsp_sum;
    assign rsp_cout  = r_rsp_cout;

endmodule

// File: tb/tb_adder_share_arbiter.sv
// Directed bench for adder_share_arbiter: table of single operations plus
// hand-written reset, fairness, backpressure and skip sequences.
module tb_adder_share_arbiter;

    localparam int N    = 8;
    localparam int NREQ = 4;
    localparam int ID_W = 2;

    logic              clk = 1'b0;
    logic              rst;
    logic [NREQ-1:0]   req;
    logic [NREQ*N-1:0] a_bus;
    logic [NREQ*N-1:0] b_bus;
    logic [NREQ-1:0]   cin;
    logic [NREQ-1:0]   gnt;
    logic              busy;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [ID_W-1:0]   rsp_id;
    logic [N-1:0]      rsp_sum;
    logic              rsp_cout;

    int unsigned total = 0;
    int unsigned bad   = 0;

    adder_share_arbiter #(.N(N), .NREQ(NREQ), .ID_W(ID_W), .SETTLE(1)) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .a_bus     (a_bus),
        .b_bus     (b_bus),
        .cin       (cin),
        .gnt       (gnt),
        .busy      (busy),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_id    (rsp_id),
        .rsp_sum   (rsp_sum),
        .rsp_cout  (rsp_cout)
    );

    always #5 clk = ~clk;

    typedef struct {
        int         k;
        logic [7:0] a;
        logic [7:0] b;
        logic       c;
        logic [7:0] sum;
        logic       cout;
    } vec_t;

    vec_t vecs [8];

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", nm, got, exp);
        end
    endtask

    task automatic set_lane(input int k, input logic [7:0] a, input logic [7:0] b, input logic c);
        a_bus[k*N +: N] = a;
        b_bus[k*N +: N] = b;
        cin[k]          = c;
    endtask

    // Advances at least one cycle, stops on the first cycle with a grant pulse.
    task automatic wait_gnt(input string nm, output int unsigned n);
        n = 0;
        do begin
            tick();
            n++;
        end while (gnt == '0 && n < 20);
        if (gnt == '0) chk({nm, "_timeout"}, 32'(gnt != '0), 32'd1);
    endtask

    task automatic drain;
        int unsigned n;
        n = 0;
        while ((busy || rsp_valid) && n < 20) begin
            tick();
            n++;
        end
        chk("drain_idle", 32'(busy), 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        int unsigned n;

        vecs[0] = '{2, 8'h3C, 8'h0F, 1'b1, 8'h4C, 1'b0};
        vecs[1] = '{0, 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1};
        vecs[2] = '{0, 8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1};
        vecs[3] = '{1, 8'h80, 8'h80, 1'b0, 8'h00, 1'b1};
        vecs[4] = '{3, 8'h55, 8'hAA, 1'b0, 8'hFF, 1'b0};
        vecs[5] = '{3, 8'h55, 8'hAA, 1'b1, 8'h00, 1'b1};
        vecs[6] = '{1, 8'h00, 8'h00, 1'b1, 8'h01, 1'b0};
        vecs[7] = '{2, 8'h7F, 8'h01, 1'b0, 8'h80, 1'b0};

        rst = 1'b1; req = '0; rsp_ready = 1'b0;
        a_bus = '0; b_bus = '0; cin = '0;
        tick();
        tick();
        chk("rst_gnt",  32'(gnt), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_vld",  32'(rsp_valid), 32'd0);
        chk("rst_sum",  32'(rsp_sum), 32'd0);
        rst = 1'b0;

        // T1: async reset in the middle of SETTLE, pointer returns to 0
        set_lane(0, 8'h11, 8'h22, 1'b0);
        set_lane(1, 8'h01, 8'h01, 1'b0);
        set_lane(2, 8'h02, 8'h02, 1'b0);
        set_lane(3, 8'h03, 8'h03, 1'b0);
        req = 4'b1111; rsp_ready = 1'b1;
        wait_gnt("t1_g0", n);
        chk("t1_gnt0", 32'(gnt), 32'h1);
        chk("t1_lat0", n, 32'd1);
        tick();
        chk("t1_vld0", 32'(rsp_valid), 32'd1);
        chk("t1_sum0", 32'(rsp_sum), 32'h33);
        tick();
        tick();
        chk("t1_gnt1", 32'(gnt), 32'h2);
        chk("t1_busy", 32'(busy), 32'd1);
        #2 rst = 1'b1;
        #1;
        chk("t1_r_gnt",  32'(gnt), 32'd0);
        chk("t1_r_busy", 32'(busy), 32'd0);
        chk("t1_r_vld",  32'(rsp_valid), 32'd0);
        chk("t1_r_id",   32'(rsp_id), 32'd0);
        chk("t1_r_sum",  32'(rsp_sum), 32'd0);
        chk("t1_r_cout", 32'(rsp_cout), 32'd0);
        #1 rst = 1'b0;
        tick();
        chk("t1_post_gnt", 32'(gnt), 32'h1);
        req = '0;
        tick();
        chk("t1_post_vld", 32'(rsp_valid), 32'd1);
        chk("t1_post_sum", 32'(rsp_sum), 32'h33);
        drain();

        // T2/T3: table of single operations, other lanes hold junk
        for (int i = 0; i < 8; i++) begin
            a_bus = 32'hA5C3_9E71; b_bus = 32'h5A3C_E117; cin = 4'b1111;
            set_lane(vecs[i].k, vecs[i].a, vecs[i].b, vecs[i].c);
            req = 4'(1 << vecs[i].k);
            rsp_ready = 1'b1;
            wait_gnt("tab_g", n);
            chk($sformatf("tab%0d_gnt", i), 32'(gnt), 32'(1 << vecs[i].k));
            chk($sformatf("tab%0d_lat", i), n, 32'd1);
            req = '0;
            set_lane(vecs[i].k, ~vecs[i].a, 8'h5D, ~vecs[i].c);
            tick();
            chk($sformatf("tab%0d_gpulse", i), 32'(gnt), 32'd0);
            chk($sformatf("tab%0d_vld", i), 32'(rsp_valid), 32'd1);
            chk($sformatf("tab%0d_sum", i), 32'(rsp_sum), 32'(vecs[i].sum));
            chk($sformatf("tab%0d_cout", i), 32'(rsp_cout), 32'(vecs[i].cout));
            chk($sformatf("tab%0d_id", i), 32'(rsp_id), 32'(vecs[i].k));
            tick();
            chk($sformatf("tab%0d_done", i), 32'(rsp_valid), 32'd0);
            chk($sformatf("tab%0d_idle", i), 32'(busy), 32'd0);
        end

        // T4: fairness from a fresh pointer
        rst = 1'b1; req = '0;
        tick();
        rst = 1'b0;
        req = 4'b1111; rsp_ready = 1'b1;
        wait_gnt("t4_g0", n);
        chk("t4_gnt0", 32'(gnt), 32'h1);
        for (int i = 1; i <= 4; i++) begin
            wait_gnt("t4_g", n);
            chk($sformatf("t4_gnt%0d", i), 32'(gnt), 32'(1 << (i % 4)));
            chk($sformatf("t4_gap%0d", i), n, 32'd3);
        end
        req = '0;
        drain();

        // T5: backpressure; pointer is 1, so requester 0 is reached by wrapping
        set_lane(0, 8'h12, 8'h34, 1'b0);
        set_lane(1, 8'h01, 8'h02, 1'b0);
        rsp_ready = 1'b0;
        req = 4'b0001;
        wait_gnt("t5_g0", n);
        chk("t5_gnt0", 32'(gnt), 32'h1);
        req = 4'b1010;
        tick();
        chk("t5_vld", 32'(rsp_valid), 32'd1);
        chk("t5_sum", 32'(rsp_sum), 32'h46);
        for (int i = 0; i < 5; i++) begin
            tick();
            chk($sformatf("t5_hold_vld%0d", i), 32'(rsp_valid), 32'd1);
            chk($sformatf("t5_hold_sum%0d", i), 32'(rsp_sum), 32'h46);
            chk($sformatf("t5_hold_id%0d", i), 32'(rsp_id), 32'd0);
            chk($sformatf("t5_hold_gnt%0d", i), 32'(gnt), 32'd0);
        end
        rsp_ready = 1'b1;
        tick();
        chk("t5_drop_vld", 32'(rsp_valid), 32'd0);
        chk("t5_drop_gnt", 32'(gnt), 32'd0);
        wait_gnt("t5_g1", n);
        chk("t5_gnt1", 32'(gnt), 32'h2);
        chk("t5_gnt1_lat", n, 32'd1);
        req = 4'b1000;
        tick();
        chk("t5_sum1", 32'(rsp_sum), 32'h03);
        chk("t5_id1", 32'(rsp_id), 32'd1);
        req = '0;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk($sformatf("t5_nogrant%0d", i), 32'(gnt), 32'd0);
        end
        chk("t5_idle", 32'(busy), 32'd0);

        // T6: set pointer to 1 via requester 0, then req=1001 grants 3 before 0
        req = 4'b0001;
        wait_gnt("t6_pre", n);
        chk("t6_pre_gnt", 32'(gnt), 32'h1);
        req = '0;
        drain();
        req = 4'b1001;
        wait_gnt("t6_g0", n);
        chk("t6_gnt3", 32'(gnt), 32'h8);
        wait_gnt("t6_g1", n);
        chk("t6_gnt0", 32'(gnt), 32'h1);
        chk("t6_gap", n, 32'd3);
        req = '0;
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
